// File: rtl/ps2_packet_assembler.sv
// Groups validated PS/2 mouse bytes into 3-byte packets (status, X, Y).
// Resynchronises on bit 3 of the first byte and abandons packets left idle too long.
module ps2_packet_assembler #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_signal1,
  output logic [7:0] o_signal2,
  output logic [7:0] o_signal3,
  output logic [7:0] o_signal4,
  output logic       o_packet_valid,
  output logic       o_sync_error,
  output logic       o_timeout,
  output logic [7:0] o_packet_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    WAIT_B1 = 2'd0,
    WAIT_B2 = 2'd1,
    WAIT_B3 = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   idle_reg, idle_next;
  logic [7:0]      byte1_reg, byte2_reg;
  logic [7:0]      signal1_reg, signal2_reg, signal3_reg;
  logic [7:0]      count_reg;
  logic            packet_valid_reg, sync_error_reg, timeout_reg;
  logic            timeout_hit;
  logic            capture_b1, capture_b2, complete, sync_err;

  // A strobe in the timeout cycle wins, so the timeout requires an idle input.
  assign timeout_hit = (state_reg != WAIT_B1) && !i_byte_valid && (idle_reg >= CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= WAIT_B1;
      idle_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idle_reg  <= idle_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_B1: if (i_byte_valid && i_byte[3]) state_next = WAIT_B2;
      WAIT_B2: begin
        if (i_byte_valid)     state_next = WAIT_B3;
        else if (timeout_hit) state_next = WAIT_B1;
      end
      WAIT_B3: begin
        if (i_byte_valid)     state_next = WAIT_B1;
        else if (timeout_hit) state_next = WAIT_B1;
      end
      default: state_next = WAIT_B1;
    endcase
  end

  always_comb begin
    capture_b1 = (state_reg == WAIT_B1) && i_byte_valid && i_byte[3];
    sync_err   = (state_reg == WAIT_B1) && i_byte_valid && !i_byte[3];
    capture_b2 = (state_reg == WAIT_B2) && i_byte_valid;
    complete   = (state_reg == WAIT_B3) && i_byte_valid;
    if (state_reg == WAIT_B1 || i_byte_valid || timeout_hit)
      idle_next = '0;
    else if (idle_reg == CNT_MAX)
      idle_next = idle_reg;
    else
      idle_next = idle_reg + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte1_reg        <= 8'h00;
      byte2_reg        <= 8'h00;
      signal1_reg      <= 8'h00;
      signal2_reg      <= 8'h00;
      signal3_reg      <= 8'h00;
      count_reg        <= 8'h00;
      packet_valid_reg <= 1'b0;
      sync_error_reg   <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      if (capture_b1) byte1_reg <= i_byte;
      if (capture_b2) byte2_reg <= i_byte;
      if (complete) begin
        signal1_reg <= byte1_reg;
        signal2_reg <= byte2_reg;
        signal3_reg <= i_byte;
        count_reg   <= count_reg + 8'd1;
      end
      packet_valid_reg <= complete;
      sync_error_reg   <= sync_err;
      timeout_reg      <= timeout_hit;
    end
  end

  assign o_signal1      = signal1_reg;
  assign o_signal2      = signal2_reg;
  assign o_signal3      = signal3_reg;
  assign o_signal4      = 8'h00;
  assign o_packet_count = count_reg;
  assign o_packet_valid = packet_valid_reg;
  assign o_sync_error   = sync_error_reg;
  assign o_timeout      = timeout_reg;

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_ps2_packet_assembler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic [7:0] s1, s2, s3, s4, cnt;
  logic       pv, se, tmo;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes of the packet in progress and edges since the last accepted byte.
  logic [7:0] m_part[$];
  int         m_since;
  logic [7:0] m_s1, m_s2, m_s3, m_cnt;
  logic       m_pv, m_se, m_to;

  ps2_packet_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_signal1(s1), .o_signal2(s2), .o_signal3(s3), .o_signal4(s4),
    .o_packet_valid(pv), .o_sync_error(se), .o_timeout(tmo), .o_packet_count(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_part.delete();
    m_since = 0;
    {m_s1, m_s2, m_s3, m_cnt} = '0;
    {m_pv, m_se, m_to} = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    m_pv = 0; m_se = 0; m_to = 0;
    if (v) begin
      m_since = 0;
      if (m_part.size() == 0) begin
        if (b[3]) m_part.push_back(b);
        else      m_se = 1;
      end else if (m_part.size() == 1) begin
        m_part.push_back(b);
      end else begin
        m_s1 = m_part[0]; m_s2 = m_part[1]; m_s3 = b;
        m_cnt = m_cnt + 8'd1;
        m_pv = 1;
        m_part.delete();
        $display("packet %0d: %02h %02h %02h", m_cnt, m_s1, m_s2, m_s3);
      end
    end else if (m_part.size() > 0) begin
      m_since++;
      if (m_since == TO) begin
        m_to = 1;
        m_part.delete();
      end
    end
  endtask

  // One clock: drive inputs, let the edge sample them, advance the model.
  task automatic step(input logic v, input logic [7:0] b);
    i_byte_valid = v;
    i_byte = b;
    @(posedge clk);
    #1;
    model_step(v, b);
    i_byte_valid = 1'b0;
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({s1, s2, s3, cnt, pv, se, tmo} !== 35'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", {s1, s2, s3, cnt, pv, se, tmo});
    end
    total++;
    if (s4 !== 8'h00) begin
      bad++;
      $display("FAIL reset_signal4: got %h required 00", s4);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(1, 8'h09);
    step(1, 8'h05);
    step(1, 8'hFB);
    total++;
    if ({s1, s2, s3, pv, cnt} !== {8'h09, 8'h05, 8'hFB, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL basic_packet: got %h required %h", {s1, s2, s3, pv, cnt}, {8'h09, 8'h05, 8'hFB, 1'b1, 8'd1});
    end
    step(0, 8'h00);
    total++;
    if (pv !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse_width: got %b required 0", pv);
    end
  endtask

  task automatic test_sync_error();
    step(1, 8'h05);
    total++;
    if ({se, pv, tmo} !== 3'b100) begin
      bad++;
      $display("FAIL sync_pulse: got %b required 100", {se, pv, tmo});
    end
    step(1, 8'h08);
    total++;
    if (se !== 1'b0) begin
      bad++;
      $display("FAIL sync_pulse_width: got %b required 0", se);
    end
    step(1, 8'h01);
    step(1, 8'h02);
    total++;
    if ({s1, s2, s3, pv, cnt} !== {8'h08, 8'h01, 8'h02, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL sync_packet: got %h required %h", {s1, s2, s3, pv, cnt}, {8'h08, 8'h01, 8'h02, 1'b1, 8'd2});
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    step(1, 8'h08);
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00);
      if (tmo) pulses++;
      total++;
      if (tmo !== (i == TO - 1)) begin
        bad++;
        $display("FAIL timeout_cycle idle=%0d: got %b required %b", i, tmo, (i == TO - 1));
      end
    end
    total++;
    if (pulses != 1 || {s1, s2, s3} !== {8'h08, 8'h01, 8'h02}) begin
      bad++;
      $display("FAIL timeout_hold: pulses=%0d signals=%h required 1 / 080102", pulses, {s1, s2, s3});
    end
    step(1, 8'h18);
    step(1, 8'h10);
    step(1, 8'h20);
    total++;
    if ({s1, s2, s3, pv, cnt} !== {8'h18, 8'h10, 8'h20, 1'b1, 8'd3}) begin
      bad++;
      $display("FAIL timeout_recover: got %h required %h", {s1, s2, s3, pv, cnt}, {8'h18, 8'h10, 8'h20, 1'b1, 8'd3});
    end
  endtask

  task automatic test_timeout_boundary();
    int pulses = 0;
    step(1, 8'h18);
    for (int i = 0; i < TO - 1; i++) begin
      step(0, 8'h00);
      if (tmo) pulses++;
    end
    step(1, 8'h33);
    if (tmo) pulses++;
    step(1, 8'h44);
    total++;
    if (pulses != 0 || {s1, s2, s3, pv} !== {8'h18, 8'h33, 8'h44, 1'b1}) begin
      bad++;
      $display("FAIL boundary_accept: pulses=%0d got %h required 0 / 183344 valid", pulses, {s1, s2, s3, pv});
    end
    step(1, 8'h09);
    step(1, 8'h55);
    pulses = 0;
    for (int i = 0; i < TO; i++) begin
      step(0, 8'h00);
      if (tmo) pulses++;
    end
    total++;
    if (pulses != 1 || tmo !== 1'b1) begin
      bad++;
      $display("FAIL b3_timeout: pulses=%0d last=%b required 1/1", pulses, tmo);
    end
  endtask

  task automatic test_async_reset();
    async_reset_pulse();
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h08);
      step(1, 8'(k));
      step(1, 8'(k + 1));
    end
    total++;
    if (cnt !== 8'd5) begin
      bad++;
      $display("FAIL pre_reset_count: got %0d required 5", cnt);
    end
    step(1, 8'h08);
    step(1, 8'h00);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({s1, s2, s3, s4, cnt, pv, se, tmo} !== 43'h0) begin
      bad++;
      $display("FAIL async_reset_outputs: got %h required 0", {s1, s2, s3, s4, cnt, pv, se, tmo});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 8'h08);
    step(1, 8'h00);
    step(1, 8'h00);
    total++;
    if ({s1, s2, s3, pv, cnt} !== {8'h08, 8'h00, 8'h00, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL post_reset_packet: got %h required %h", {s1, s2, s3, pv, cnt}, {8'h08, 8'h00, 8'h00, 1'b1, 8'd1});
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    async_reset_pulse();
    for (int k = 0; k < 256; k++) begin
      step(1, 8'h08 | 8'(k));
      if (pv) pulses++;
      step(1, 8'(k));
      if (pv) pulses++;
      step(1, ~8'(k));
      if (pv) pulses++;
      if (k == 254) begin
        total++;
        if (cnt !== 8'hFF) begin
          bad++;
          $display("FAIL count_ff: got %h required ff", cnt);
        end
      end
    end
    total++;
    if (pulses != 256 || cnt !== 8'h00) begin
      bad++;
      $display("FAIL count_wrap: pulses=%0d count=%h required 256/00", pulses, cnt);
    end
  endtask

  task automatic test_random();
    int gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (gap > 0) begin
        gap--;
        step(0, 8'h00);
      end else begin
        step(1, 8'($urandom));
        gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 3)) : int'($urandom_range(0, 2));
      end
      total++;
      if ({s1, s2, s3, cnt, pv, se, tmo} !== {m_s1, m_s2, m_s3, m_cnt, m_pv, m_se, m_to}) begin
        bad++;
        $display("FAIL random_cycle %0d: got %h required %h", c,
                 {s1, s2, s3, cnt, pv, se, tmo}, {m_s1, m_s2, m_s3, m_cnt, m_pv, m_se, m_to});
      end
      total++;
      if ((int'(pv) + int'(se) + int'(tmo)) > 1) begin
        bad++;
        $display("FAIL pulse_exclusive %0d: got %b required at most one", c, {pv, se, tmo});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_sync_error();
    test_timeout();
    test_timeout_boundary();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
